bcd_updown_counter: RTL and testbench

//   N-digit BCD up/down counter with programmable modulus, synchronous clear,

---
 rtl/bcd_updown_counter.sv | 135 +++++++++++++
 tb/tb_bcd_updown_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with programmable modulus, synchronous clear,
// checked parallel load, and wrap or saturate behaviour at the range ends.
module bcd_updown_counter #(
  parameter int N        = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           up,
  input  logic           clear,
  input  logic           load,
  input  logic [4*N-1:0] load_value,
  input  logic [4*N-1:0] modulus,
  output logic [4*N-1:0] d,
  output logic           carry_out,
  output logic           borrow_out,
  output logic           is_zero,
  output logic           is_max,
  output logic           load_err
);

  localparam int W = 4 * N;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Range-end handling: wrap to the opposite end, or clamp when saturating.
  function automatic logic [W-1:0] count_step(input logic [W-1:0] v,
                                              input logic           dir_up,
                                              input logic           top,
                                              input logic           bottom,
                                              input logic [W-1:0] max_v);
    logic [W-1:0] r;
    if (dir_up) begin
      if (top) r = SATURATE ? max_v : '0;
      else     r = bcd_inc(v);
    end else begin
      if (bottom) r = SATURATE ? '0 : max_v;
      else        r = bcd_dec(v);
    end
    return r;
  endfunction

  logic [W-1:0] cnt_p0;
  logic [W-1:0] cnt_next;
  logic [W-1:0] max_val;
  logic         err_p0;
  logic         err_next;
  logic         at_top;
  logic         at_zero;
  logic         load_ok;
  logic         step_ok;

  always_comb begin
    // A zero modulus decrements to all nines, which is exactly 10^N - 1.
    max_val  = bcd_dec(modulus);
    at_top   = (cnt_p0 >= max_val);
    at_zero  = (cnt_p0 == '0);
    load_ok  = bcd_valid(load_value) &&
               ((modulus == '0) || (load_value < modulus));
    step_ok  = en && !clear && !load;
    cnt_next = cnt_p0;
    err_next = 1'b0;
    if (clear) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = load_ok ? load_value : '0;
      err_next = !load_ok;
    end else if (en) begin
      cnt_next = count_step(cnt_p0, up, at_top, at_zero, max_val);
    end
  end

  // Stage p0: count and load-error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0 <= '0;
      err_p0 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_next;
      err_p0 <= err_next;
    end
  end

  assign d          = cnt_p0;
  assign load_err   = err_p0;
  assign is_zero    = at_zero;
  assign is_max     = (cnt_p0 == max_val);
  assign carry_out  = (SATURATE == 1'b0) && step_ok && up && at_top;
  assign borrow_out = (SATURATE == 1'b0) && step_ok && !up && at_zero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (N=2 wrap, N=2 saturate,
// N=3 wrap) share stimulus and are compared against an integer model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
  logic [11:0] load_value = '0;
  logic [11:0] modulus = '0;
  logic [7:0]  d0, d1;
  logic [11:0] d2;
  logic        co [3];
  logic        bo [3];
  logic        iz [3];
  logic        im [3];
  logic        le [3];
  int          checks = 0;
  int          errors = 0;
  int          cnt [3] = '{0, 0, 0};
  bit          err [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  bcd_updown_counter #(.N(2), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value[7:0]), .modulus(modulus[7:0]), .d(d0),
    .carry_out(co[0]), .borrow_out(bo[0]), .is_zero(iz[0]), .is_max(im[0]),
    .load_err(le[0]));

  bcd_updown_counter #(.N(2), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value[7:0]), .modulus(modulus[7:0]), .d(d1),
    .carry_out(co[1]), .borrow_out(bo[1]), .is_zero(iz[1]), .is_max(im[1]),
    .load_err(le[1]));

  bcd_updown_counter #(.N(3), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .modulus(modulus), .d(d2),
    .carry_out(co[2]), .borrow_out(bo[2]), .is_zero(iz[2]), .is_max(im[2]),
    .load_err(le[2]));

  function automatic int ndig(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic bit sat(int i);
    return (i == 1);
  endfunction

  function automatic int pow10(int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(logic [11:0] v, int n);
    int r = 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (v[4*k +: 4] > 4'd9) return -1;
      r = r * 10 + int'(v[4*k +: 4]);
    end
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(int x);
    logic [11:0] r = '0;
    int t = x;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int mod_of(int i);
    int m = bcd2int(modulus, ndig(i));
    if (m == 0) m = pow10(ndig(i));
    return m;
  endfunction

  function automatic bit load_good(int i);
    int lv = bcd2int(load_value, ndig(i));
    return (lv >= 0) && (lv < mod_of(i));
  endfunction

  function automatic bit ex_carry(int i);
    return !sat(i) && en && up && !clear && !load && (cnt[i] >= mod_of(i) - 1);
  endfunction

  function automatic bit ex_borrow(int i);
    return !sat(i) && en && !up && !clear && !load && (cnt[i] == 0);
  endfunction

  function automatic int nxt_cnt(int i);
    int m = mod_of(i);
    if (clear) return 0;
    if (load)  return load_good(i) ? bcd2int(load_value, ndig(i)) : 0;
    if (!en)   return cnt[i];
    if (up)    return (cnt[i] >= m - 1) ? (sat(i) ? m - 1 : 0) : cnt[i] + 1;
    return (cnt[i] == 0) ? (sat(i) ? 0 : m - 1) : cnt[i] - 1;
  endfunction

  function automatic bit nxt_err(int i);
    return !clear && load && !load_good(i);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        cnt[i] <= 0;
        err[i] <= 1'b0;
      end else begin
        cnt[i] <= nxt_cnt(i);
        err[i] <= nxt_err(i);
      end
    end
  end

  function automatic logic [11:0] dut_d(int i);
    case (i)
      0:       return {4'h0, d0};
      1:       return {4'h0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic expect_d(int i, logic [11:0] e, string nm);
    check(nm, dut_d(i), e);
    check({nm, "_model"}, int2bcd(cnt[i]), e);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_d", i), dut_d(i), int2bcd(cnt[i]));
      check($sformatf("u%0d_carry", i), {11'b0, co[i]}, {11'b0, ex_carry(i)});
      check($sformatf("u%0d_borrow", i), {11'b0, bo[i]}, {11'b0, ex_borrow(i)});
      check($sformatf("u%0d_is_zero", i), {11'b0, iz[i]}, {11'b0, cnt[i] == 0});
      check($sformatf("u%0d_is_max", i), {11'b0, im[i]},
            {11'b0, cnt[i] == mod_of(i) - 1});
      check($sformatf("u%0d_load_err", i), {11'b0, le[i]}, {11'b0, err[i]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] t2 [7] = '{12'h004, 12'h003, 12'h002, 12'h001, 12'h000,
                          12'h059, 12'h058};

  initial begin
    step();
    step();
    reset_n = 1'b1;
    expect_d(0, 12'h000, "reset_d");
    check("reset_is_zero", {11'b0, iz[0]}, 12'h001);
    check("reset_load_err", {11'b0, le[0]}, 12'h000);

    // Count up through the modulus-60 range.
    modulus = 12'h060; up = 1'b1; en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 9)  expect_d(0, 12'h009, "up_09");
      if (k == 10) expect_d(0, 12'h010, "ripple_10");
      if (k == 59) begin
        expect_d(0, 12'h059, "up_59");
        check("carry_at_59", {11'b0, co[0]}, 12'h001);
        check("sat_no_carry", {11'b0, co[1]}, 12'h000);
      end
      if (k == 60) begin
        expect_d(0, 12'h000, "wrap_00");
        expect_d(1, 12'h059, "sat_hold_59");
      end
    end
    en = 1'b0;

    // Load 05, then count down across zero.
    load_value = 12'h005; load = 1'b1;
    step();
    load = 1'b0;
    expect_d(0, 12'h005, "load_05");
    up = 1'b0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      expect_d(0, t2[k], $sformatf("down_%0d", k));
      if (k == 4) check("borrow_at_00", {11'b0, bo[0]}, 12'h001);
    end
    en = 1'b0;

    // Saturating instance, modulus 12.
    modulus = 12'h012; load_value = 12'h010; load = 1'b1;
    step();
    load = 1'b0;
    expect_d(1, 12'h010, "sat_load_10");
    up = 1'b1; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_d(1, 12'h011, $sformatf("sat_up_%0d", k));
      check("sat_carry_0", {11'b0, co[1]}, 12'h000);
      if (k == 0) check("wrap_carry_at_11", {11'b0, co[0]}, 12'h001);
    end
    en = 1'b0; load_value = 12'h001; load = 1'b1;
    step();
    load = 1'b0;
    expect_d(1, 12'h001, "sat_load_01");
    up = 1'b0; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      expect_d(1, 12'h000, $sformatf("sat_down_%0d", k));
      check("sat_is_zero", {11'b0, iz[1]}, 12'h001);
    end
    en = 1'b0;

    // Load validity: bad digit, out of range, then a good value.
    modulus = 12'h050; load = 1'b1; load_value = 12'h07A;
    step();
    expect_d(0, 12'h000, "bad_digit_d");
    check("bad_digit_err", {11'b0, le[0]}, 12'h001);
    load_value = 12'h055;
    step();
    expect_d(0, 12'h000, "over_m_d");
    check("over_m_err", {11'b0, le[0]}, 12'h001);
    load_value = 12'h042;
    step();
    expect_d(0, 12'h042, "good_load_d");
    check("good_load_err", {11'b0, le[0]}, 12'h000);

    // Priority and asynchronous reset.
    load_value = 12'h033;
    step();
    expect_d(0, 12'h033, "load_33");
    clear = 1'b1; en = 1'b1; up = 1'b1; load_value = 12'h020;
    step();
    expect_d(0, 12'h000, "clear_wins");
    clear = 1'b0;
    step();
    expect_d(0, 12'h020, "load_beats_en");
    load_value = 12'h047; en = 1'b0;
    step();
    expect_d(0, 12'h047, "load_47");
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_d0", dut_d(0), 12'h000);
    check("async_rst_d2", dut_d(2), 12'h000);
    check("async_rst_zero", {11'b0, iz[0]}, 12'h001);
    @(posedge clk);
    #1;
    reset_n = 1'b1; en = 1'b0;
    expect_d(0, 12'h000, "after_rst");

    // Three digits, modulus 1000, then modulus lowered below the count.
    modulus = 12'h000; load_value = 12'h998; load = 1'b1;
    step();
    load = 1'b0;
    expect_d(2, 12'h998, "load_998");
    en = 1'b1; up = 1'b1;
    step();
    expect_d(2, 12'h999, "up_999");
    check("carry_at_999", {11'b0, co[2]}, 12'h001);
    step();
    expect_d(2, 12'h000, "wrap_000");
    en = 1'b0; load_value = 12'h500; load = 1'b1;
    step();
    load = 1'b0;
    expect_d(2, 12'h500, "load_500");
    modulus = 12'h100; en = 1'b1; up = 1'b1;
    #1;
    check("carry_over_m", {11'b0, co[2]}, 12'h001);
    step();
    expect_d(2, 12'h000, "over_m_wrap");
    en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
